// File: rtl/fetch_queue_unit_if.sv
// Signal bundle of the fetch unit: BIU read port, redirect input and prefetch queue head.
`timescale 1ns/1ps
interface fetch_queue_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned BUS_W  = 16,
    parameter int unsigned WORDS  = 2,
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned INSTR_W = BUS_W * WORDS;
    localparam int unsigned LVL_W   = $clog2(QDEPTH) + 1;

    logic               biu_req;
    logic [ADDR_W-1:0]  biu_addr;
    logic               biu_ack;
    logic [BUS_W-1:0]   biu_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic [LVL_W-1:0]   q_level;

    modport master (
        output biu_req, biu_addr, instr_valid, instr, instr_pc, q_level,
        input  biu_ack, biu_data, redirect, redirect_addr, instr_ready
    );

    modport slave (
        input  biu_req, biu_addr, instr_valid, instr, instr_pc, q_level,
        output biu_ack, biu_data, redirect, redirect_addr, instr_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: gathers WORDS bus words per instruction (MSW first) into a
// QDEPTH-entry prefetch queue tagged with the fetch address; redirect flushes everything.
`timescale 1ns/1ps
module fetch_queue_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned BUS_W    = 16,
    parameter int unsigned WORDS    = 2,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned INSTR_W = BUS_W * WORDS;
    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [LVL_W-1:0]  NEAR_FULL = LVL_W'(QDEPTH - 1);

    typedef enum logic {FETCH, HOLD} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_t             state_q, state_d;
    logic               req_en_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [INSTR_W-1:0] asm_q;
    logic [ADDR_W-1:0]  asm_pc_q;
    entry_t             mem_q [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0]   count_q;

    logic               ack_c, last_c, push_c, pop_c;
    logic [INSTR_W-1:0] asm_c;
    logic [ADDR_W-1:0]  first_pc_c;

    // Accepted-ack, push/pop qualification and the assembly buffer with the incoming word merged in.
    always_comb begin
        ack_c      = bus.biu_ack & req_en_q & (state_q == FETCH) & ~bus.redirect;
        last_c     = (wcnt_q == LAST_WORD);
        push_c     = ack_c & last_c;
        pop_c      = (count_q != '0) & bus.instr_ready & ~bus.redirect;
        first_pc_c = (wcnt_q == '0) ? pc_q : asm_pc_q;
        asm_c      = asm_q;
        for (int k = 0; k < int'(WORDS); k++) begin
            if (wcnt_q == CNT_W'(k)) begin
                asm_c[INSTR_W-1-k*BUS_W -: BUS_W] = bus.biu_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD is entered only by the push that fills the queue, so wcnt is always 0 there.
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (push_c && !pop_c && (count_q == NEAR_FULL)) begin
                state_d = HOLD;
            end
        end else if (pop_c) begin
            state_d = FETCH;
        end
    end

    // Fetch pointer, word assembly and queue storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_en_q <= 1'b0;
            pc_q     <= PC_RST;
            wcnt_q   <= '0;
            asm_q    <= '0;
            asm_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            req_en_q <= 1'b1;
            if (bus.redirect) begin
                pc_q     <= bus.redirect_addr;
                wcnt_q   <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (ack_c) begin
                    pc_q  <= pc_q + 1'b1;
                    asm_q <= asm_c;
                    if (wcnt_q == '0) begin
                        asm_pc_q <= pc_q;
                    end
                    if (last_c) begin
                        wcnt_q           <= '0;
                        mem_q[wr_ptr_q]  <= '{pc: first_pc_c, instr: asm_c};
                        wr_ptr_q         <= wr_ptr_q + 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_q + LVL_W'(push_c) - LVL_W'(pop_c);
            end
        end
    end

    // Request is held off for the first cycle after reset and dropped while reset is high.
    assign bus.biu_req     = req_en_q & ~reset & (state_q == FETCH);
    assign bus.biu_addr    = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = mem_q[rd_ptr_q].instr;
    assign bus.instr_pc    = mem_q[rd_ptr_q].pc;
    assign bus.q_level     = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: vector table, directed corner sequences,
// randomized run against a queue-based model, and parameter-variant instances.
`timescale 1ns/1ps
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    logic reset;
    logic rst_s;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_queue_unit_if b0 ();
    fetch_queue_unit_if b1 ();
    fetch_queue_unit_if #(.ADDR_W(16), .BUS_W(16), .WORDS(1), .QDEPTH(2)) b2 ();
    fetch_queue_unit_if #(.ADDR_W(16), .BUS_W(8),  .WORDS(3), .QDEPTH(4)) b3 ();

    fetch_queue_unit u0 (.clk(clk), .reset(reset), .bus(b0));
    fetch_queue_unit #(.RESET_PC(16'hFFFF)) u1 (.clk(clk), .reset(rst_s), .bus(b1));
    fetch_queue_unit #(.ADDR_W(16), .BUS_W(16), .WORDS(1), .QDEPTH(2))
        u2 (.clk(clk), .reset(rst_s), .bus(b2));
    fetch_queue_unit #(.ADDR_W(16), .BUS_W(8), .WORDS(3), .QDEPTH(4))
        u3 (.clk(clk), .reset(rst_s), .bus(b3));

    function automatic logic [15:0] d16(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [7:0] d8(input logic [15:0] a);
        return 8'(a ^ 16'hA5A5);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        ready;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        int          lvl;
        logic [15:0] ipc;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic ready, input logic req,
                                input logic [15:0] addr, input logic valid, input int lvl,
                                input logic [15:0] ipc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.req = req; v.addr = addr;
        v.valid = valid; v.lvl = lvl; v.ipc = ipc;
        return v;
    endfunction

    task automatic step(input logic ack, input logic [15:0] data, input logic ready,
                        input logic redir, input logic [15:0] raddr);
        b0.biu_ack       = ack;
        b0.biu_data      = data;
        b0.instr_ready   = ready;
        b0.redirect      = redir;
        b0.redirect_addr = raddr;
        @(negedge clk);
    endtask

    // Hold reset for two edges; returns at the negedge where reset has just been released.
    task automatic do_reset(input logic ack_in);
        b0.biu_ack     = ack_in;
        b0.biu_data    = 16'hBEEF;
        b0.redirect    = 1'b0;
        b0.instr_ready = 1'b0;
        reset          = 1'b1;
        #1;
        chk("rst_req_low", 64'(b0.biu_req), 64'd0);
        @(negedge clk);
        chk("rst_req", 64'(b0.biu_req), 64'd0);
        chk("rst_addr", 64'(b0.biu_addr), 64'd0);
        chk("rst_valid", 64'(b0.instr_valid), 64'd0);
        chk("rst_level", 64'(b0.q_level), 64'd0);
        chk("rst_instr", 64'(b0.instr), 64'd0);
        chk("rst_ipc", 64'(b0.instr_pc), 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        b0.biu_ack = 1'b0;
    endtask

    // Slow BIU with wrap: ack after 3 wait cycles, request must be held while waiting.
    int          wc1 = 0;
    logic        pend1 = 1'b0;
    logic [15:0] paddr1;
    logic [15:0] exp1 = 16'hFFFF;
    int          n1 = 0;

    always @(negedge clk) begin
        if (rst_s) begin
            b1.biu_ack = 1'b0; wc1 = 0; pend1 = 1'b0; exp1 = 16'hFFFF;
        end else begin
            if (pend1) begin
                chk("slow_req_held", 64'(b1.biu_req), 64'd1);
                chk("slow_addr_held", 64'(b1.biu_addr), 64'(paddr1));
            end
            if (b1.instr_valid) begin
                chk("slow_ipc", 64'(b1.instr_pc), 64'(exp1));
                chk("slow_instr", 64'(b1.instr), 64'({d16(exp1), d16(exp1 + 16'd1)}));
                exp1 = exp1 + 16'd2;
                n1++;
            end
            if (b1.biu_req && wc1 == 3) begin
                b1.biu_ack = 1'b1; wc1 = 0;
            end else begin
                b1.biu_ack = 1'b0;
                if (b1.biu_req) wc1++;
            end
            b1.biu_data = d16(b1.biu_addr);
            pend1  = b1.biu_req && !b1.biu_ack;
            paddr1 = b1.biu_addr;
        end
    end

    // WORDS=1, QDEPTH=2 and WORDS=3, BUS_W=8 variants with a zero-wait BIU.
    logic [15:0] exp2 = 16'h0;
    logic [15:0] exp3 = 16'h0;
    int          n2 = 0;
    int          n3 = 0;

    always @(negedge clk) begin
        if (rst_s) begin
            b2.biu_ack = 1'b0; b3.biu_ack = 1'b0; exp2 = 16'h0; exp3 = 16'h0;
        end else begin
            if (b2.instr_valid) begin
                chk("w1_ipc", 64'(b2.instr_pc), 64'(exp2));
                chk("w1_instr", 64'(b2.instr), 64'(d16(exp2)));
                exp2 = exp2 + 16'd1;
                n2++;
            end
            if (b3.instr_valid) begin
                chk("w3_ipc", 64'(b3.instr_pc), 64'(exp3));
                chk("w3_instr", 64'(b3.instr),
                    64'({d8(exp3), d8(exp3 + 16'd1), d8(exp3 + 16'd2)}));
                exp3 = exp3 + 16'd3;
                n3++;
            end
            b2.biu_ack  = b2.biu_req;
            b2.biu_data = d16(b2.biu_addr);
            b3.biu_ack  = b3.biu_req;
            b3.biu_data = d8(b3.biu_addr);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t        tbl [19];
    logic [47:0] mq [$];
    logic [15:0] mw [$];
    logic [15:0] mpc, mfirst, a;
    logic [47:0] e;
    logic        got, exp_req, ack, rdy, redir;
    logic [15:0] ra, dt;

    initial begin
        // Cycle table from reset release: fill, back-pressure to full, single pop.
        tbl[0]  = mk(0, 1, 0, 16'd0,  0, 0, 16'd0);
        tbl[1]  = mk(1, 1, 1, 16'd0,  0, 0, 16'd0);
        tbl[2]  = mk(1, 1, 1, 16'd1,  0, 0, 16'd0);
        tbl[3]  = mk(1, 1, 1, 16'd2,  1, 1, 16'd0);
        tbl[4]  = mk(1, 1, 1, 16'd3,  0, 0, 16'd0);
        tbl[5]  = mk(1, 1, 1, 16'd4,  1, 1, 16'd2);
        tbl[6]  = mk(1, 0, 1, 16'd5,  0, 0, 16'd0);
        tbl[7]  = mk(1, 0, 1, 16'd6,  1, 1, 16'd4);
        tbl[8]  = mk(1, 0, 1, 16'd7,  1, 1, 16'd4);
        tbl[9]  = mk(1, 0, 1, 16'd8,  1, 2, 16'd4);
        tbl[10] = mk(1, 0, 1, 16'd9,  1, 2, 16'd4);
        tbl[11] = mk(1, 0, 1, 16'd10, 1, 3, 16'd4);
        tbl[12] = mk(1, 0, 1, 16'd11, 1, 3, 16'd4);
        tbl[13] = mk(1, 0, 0, 16'd12, 1, 4, 16'd4);
        tbl[14] = mk(1, 0, 0, 16'd12, 1, 4, 16'd4);
        tbl[15] = mk(0, 1, 0, 16'd12, 1, 4, 16'd4);
        tbl[16] = mk(0, 0, 1, 16'd12, 1, 3, 16'd6);
        tbl[17] = mk(1, 0, 1, 16'd12, 1, 3, 16'd6);
        tbl[18] = mk(0, 0, 1, 16'd13, 1, 3, 16'd6);

        reset = 1'b1;
        rst_s = 1'b1;
        b1.redirect = 1'b0; b1.redirect_addr = '0; b1.instr_ready = 1'b1; b1.biu_data = '0;
        b2.redirect = 1'b0; b2.redirect_addr = '0; b2.instr_ready = 1'b1; b2.biu_data = '0;
        b3.redirect = 1'b0; b3.redirect_addr = '0; b3.instr_ready = 1'b1; b3.biu_data = '0;
        b0.redirect_addr = '0;
        @(negedge clk);
        do_reset(1'b0);
        rst_s = 1'b0;

        for (int r = 0; r < 19; r++) begin
            chk($sformatf("tbl%0d_req", r), 64'(b0.biu_req), 64'(tbl[r].req));
            chk($sformatf("tbl%0d_addr", r), 64'(b0.biu_addr), 64'(tbl[r].addr));
            chk($sformatf("tbl%0d_valid", r), 64'(b0.instr_valid), 64'(tbl[r].valid));
            chk($sformatf("tbl%0d_level", r), 64'(b0.q_level), 64'(tbl[r].lvl));
            if (tbl[r].valid) begin
                chk($sformatf("tbl%0d_ipc", r), 64'(b0.instr_pc), 64'(tbl[r].ipc));
                chk($sformatf("tbl%0d_instr", r), 64'(b0.instr),
                    64'({d16(tbl[r].ipc), d16(tbl[r].ipc + 16'd1)}));
            end
            step(tbl[r].ack, d16(tbl[r].addr), tbl[r].ready, 1'b0, 16'h0);
        end

        // Redirect with 2 entries queued, coinciding with a second-word ack.
        do_reset(1'b0);
        step(0, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(1, d16(16'(i)), 0, 0, 16'h0);
        chk("redir_pre_level", 64'(b0.q_level), 64'd2);
        step(1, d16(16'd5), 0, 1, 16'h0100);
        chk("redir_req", 64'(b0.biu_req), 64'd1);
        chk("redir_addr", 64'(b0.biu_addr), 64'h0100);
        chk("redir_valid", 64'(b0.instr_valid), 64'd0);
        chk("redir_level", 64'(b0.q_level), 64'd0);
        a = 16'h0100;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(1, d16(a), 1, 0, 16'h0);
            a = a + 16'd1;
            got = b0.instr_valid;
        end
        chk("redir_valid_seen", 64'(got), 64'd1);
        if (got) begin
            chk("redir_ipc", 64'(b0.instr_pc), 64'h0100);
            chk("redir_instr", 64'(b0.instr), 64'({d16(16'h0100), d16(16'h0101)}));
        end

        // Reset after the first word of an instruction.
        do_reset(1'b0);
        step(0, 16'h0, 0, 0, 16'h0);
        step(1, 16'hDEAD, 0, 0, 16'h0);
        chk("mid_wcnt_addr", 64'(b0.biu_addr), 64'd1);
        do_reset(1'b1);
        step(0, 16'h0, 0, 0, 16'h0);
        chk("mid_restart_req", 64'(b0.biu_req), 64'd1);
        chk("mid_restart_addr", 64'(b0.biu_addr), 64'd0);
        step(1, d16(16'd0), 0, 0, 16'h0);
        chk("mid_no_partial", 64'(b0.q_level), 64'd0);
        step(1, d16(16'd1), 0, 0, 16'h0);
        chk("mid_level", 64'(b0.q_level), 64'd1);
        chk("mid_ipc", 64'(b0.instr_pc), 64'd0);
        chk("mid_instr", 64'(b0.instr), 64'({d16(16'd0), d16(16'd1)}));

        // Randomized traffic against a queue model.
        do_reset(1'b0);
        step(0, 16'h0, 0, 0, 16'h0);
        mq.delete();
        mw.delete();
        mpc = 16'h0;
        for (int c = 0; c < 2000; c++) begin
            exp_req = (mq.size() < 4);
            chk("rnd_req", 64'(b0.biu_req), 64'(exp_req));
            chk("rnd_addr", 64'(b0.biu_addr), 64'(mpc));
            chk("rnd_level", 64'(b0.q_level), 64'(mq.size()));
            chk("rnd_valid", 64'(b0.instr_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                e = mq[0];
                chk("rnd_ipc", 64'(b0.instr_pc), 64'(e[47:32]));
                chk("rnd_instr", 64'(b0.instr), 64'(e[31:0]));
            end
            ack   = ($urandom_range(0, 2) != 0);
            rdy   = ($urandom_range(0, 99) < (((c / 250) % 2 == 1) ? 85 : 20));
            redir = ($urandom_range(0, 39) == 0);
            ra    = 16'($urandom);
            dt    = 16'($urandom);
            if (redir) begin
                mq.delete();
                mw.delete();
                mpc = ra;
            end else begin
                if (rdy && mq.size() != 0) void'(mq.pop_front());
                if (ack && exp_req) begin
                    if (mw.size() == 0) mfirst = mpc;
                    mw.push_back(dt);
                    mpc = mpc + 16'd1;
                    if (mw.size() == 2) begin
                        mq.push_back({mfirst, mw[0], mw[1]});
                        mw.delete();
                    end
                end
            end
            step(ack, dt, rdy, redir, ra);
        end

        chk("slow_count", 64'(n1 >= 20), 64'd1);
        chk("w1_count", 64'(n2 >= 100), 64'd1);
        chk("w3_count", 64'(n3 >= 100), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction fetch unit with a prefetch queue. It issues word reads to the bus interface unit and assembles `WORDS` consecutive bus words into one instruction. Completed instructions, tagged with their fetch address, go into a `QDEPTH`-entry FIFO. It sits between the BIU and the decode/execute stage, and supports a branch redirect that flushes all fetched state.

## Interface
- `ADDR_W`, 16, width of word address / program counter
- `BUS_W`, 16, width of one BIU data word
- `WORDS`, 2, bus words per instruction (≥1); `INSTR_W = BUS_W*WORDS`
- `QDEPTH`, 4, prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 0, fetch address after reset
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `biu_req`  out  1  word read request
- `biu_addr`  out  ADDR_W  word address of request
- `biu_ack`  in  1  one-cycle acknowledge; `biu_data` valid this cycle
- `biu_data`  in  BUS_W  read data
- `redirect`  in  1  flush and restart fetch at `redirect_addr`
- `redirect_addr`  in  ADDR_W  new fetch address
- `instr_valid`  out  1  queue head valid
- `instr`  out  INSTR_W  queue head instruction
- `instr_pc`  out  ADDR_W  address of the first word of the head instruction
- `instr_ready`  in  1  consumer takes head when `instr_valid & instr_ready`
- `q_level`  out  $clog2(QDEPTH)+1  queue occupancy

## Operation
- Registers:
  - `pc`: next word address to request.
  - `wcnt`: words of the current instruction collected so far, 0..WORDS-1.
  - `asm`: assembly buffer.
  - `asm_pc`: address of the current instruction's first word.
  - Queue storage, read/write pointers and a count.
- FSM states: FETCH, HOLD.
  - FETCH: `biu_req=1`, `biu_addr=pc`.
  - HOLD: `biu_req=0`. The unit is in HOLD when the queue is full and `wcnt==0`.
  - FETCH→HOLD: a push makes count==QDEPTH.
  - HOLD→FETCH: count drops below QDEPTH through a pop, or on redirect.
- Request rule: `biu_req` and `biu_addr` stay stable until `biu_ack`. They are withdrawn only by redirect or reset. `biu_ack` while `biu_req=0` is ignored.
- On an accepted ack:
  - The word is written into `asm`, most significant word first. Word k lands in bits `[INSTR_W-1-k*BUS_W -: BUS_W]`.
  - `pc` increments by 1, wrapping modulo 2^ADDR_W.
  - When `wcnt==0`, `asm_pc` takes the current `pc`.
  - If `wcnt==WORDS-1`, the completed instruction plus `asm_pc` are pushed and `wcnt` returns to 0. Otherwise `wcnt` increments.
- The push is guaranteed to find space: FETCH is never entered at count==QDEPTH.
- Pop: on `instr_valid & instr_ready`, the read pointer advances. Push and pop in the same cycle leave the count unchanged.
- `instr_valid = (count != 0)`. `instr`/`instr_pc` show the head entry. When empty they hold the last value and are don't-care.
- Redirect (highest priority after reset), in the cycle it is sampled:
  - Queue emptied; a pop in that cycle is void.
  - `wcnt=0`; a concurrent `biu_ack` is discarded.
  - `pc=redirect_addr`; state becomes FETCH.
- Reset: `pc=RESET_PC`, `wcnt=0`, queue empty, state FETCH. Reset mid-request abandons the request.

## Timing
- Outputs are decoded from registers; nothing is combinational from `biu_ack`, `instr_ready` or `redirect`.
- Reset values: `biu_req=0` while `reset=1`, `biu_addr=RESET_PC`, `instr_valid=0`, `instr=0`, `instr_pc=0`, `q_level=0`.
- First cycle after reset release: `biu_req=1`, `biu_addr=RESET_PC`.
- With `biu_ack` returned every cycle, an instruction completes on its WORDS-th ack. `instr_valid` rises the cycle after that ack.
- Sustained throughput is one instruction per WORDS cycles while the consumer keeps up.
- A redirect in cycle n gives `biu_addr=redirect_addr` and `instr_valid=0` in cycle n+1.
- Queue full: `biu_req` falls the cycle after the filling push. It rises the cycle after the first pop.

## Test plan
- **Straight-line fetch:**
  - Setup: defaults; BIU acks every cycle with `biu_data=addr^16'hA5A5`; `instr_ready=1`.
  - Required: `instr_pc` sequence 0,2,4,…; `instr={d(0),d(1)}`, etc.; `instr_valid` first high 3 cycles after reset release.
- **Back-pressure:**
  - Setup: `instr_ready=0`.
  - Required: exactly 4 instructions queued; `q_level=4`; `biu_req=0`; no more acks are accepted.
  - Then raise `instr_ready` for 1 cycle: `q_level=3`, `biu_req=1` the next cycle.
- **Redirect:**
  - Setup: `redirect=1`, `redirect_addr=16'h0100` in the same cycle as an ack of the second word, with 2 entries queued.
  - Required: queue empties; ack data dropped; next `biu_addr=16'h0100`; next `instr_pc=16'h0100`.
- **Slow BIU and wrap:**
  - Setup: `RESET_PC=16'hFFFF`; ack after 3 wait cycles.
  - Required: `biu_addr` held stable while waiting; `instr_pc=16'hFFFF` with words from FFFF and 0000; next `instr_pc=16'h0001`.
- **Reset mid-assembly:**
  - Setup: assert reset after the first word of an instruction.
  - Required: after release, fetch restarts at `RESET_PC`; no partial instruction is ever pushed.
- **Parameter sweep:**
  - Setup: `WORDS=1`, `QDEPTH=2` and `WORDS=3`, `BUS_W=8`.
  - Required: the first scenario holds with word ordering MSW-first.
